// File: rtl/fp16_accum.sv
// FP16 streaming accumulator: sums len_i half-precision elements through a combinational adder.
// Optional sticky overflow output ovf_o is enabled by defining FP16_ACCUM_OVF_FLAG_EN.
`timescale 1ns/1ps

module fp16_add (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_sum
);
    logic [15:0] w_big;
    logic [15:0] w_small;
    logic [4:0]  w_expBig;
    logic [4:0]  w_expSmall;
    logic [4:0]  w_diff;
    logic [4:0]  w_lz;
    logic [4:0]  w_maxShift;
    logic [4:0]  w_shift;
    logic [13:0] w_manBig;
    logic [13:0] w_manSmall;
    logic [13:0] w_lostMask;
    logic [13:0] w_aligned;
    logic [13:0] w_norm;
    logic [14:0] w_raw;
    logic [5:0]  w_exp;
    logic [5:0]  w_expRnd;
    logic [11:0] w_manRnd;
    logic        w_sticky;
    logic        w_roundUp;
    logic        w_special;

    // Mantissas carry three extra bits (guard, round, sticky) for round-to-nearest-even.
    always_comb begin
        if (i_a[14:0] >= i_b[14:0]) begin
            w_big   = i_a;
            w_small = i_b;
        end else begin
            w_big   = i_b;
            w_small = i_a;
        end
        w_special  = (&i_a[14:10]) | (&i_b[14:10]);
        w_expBig   = (w_big[14:10] == 5'd0) ? 5'd1 : w_big[14:10];
        w_expSmall = (w_small[14:10] == 5'd0) ? 5'd1 : w_small[14:10];
        w_diff     = w_expBig - w_expSmall;
        w_manBig   = {|w_big[14:10], w_big[9:0], 3'b000};
        w_manSmall = {|w_small[14:10], w_small[9:0], 3'b000};
        w_lostMask = (14'd1 << w_diff) - 14'd1;
        w_sticky   = |(w_manSmall & w_lostMask);
        w_aligned  = w_manSmall >> w_diff;
        w_aligned[0] = w_aligned[0] | w_sticky;

        if (w_big[15] == w_small[15])
            w_raw = {1'b0, w_manBig} + {1'b0, w_aligned};
        else
            w_raw = {1'b0, w_manBig} - {1'b0, w_aligned};

        w_lz = 5'd14;
        for (int i = 0; i < 14; i++) begin
            if (w_raw[i])
                w_lz = 5'(13 - i);
        end
        // Left shift is capped so tiny results land in the subnormal range.
        w_maxShift = w_expBig - 5'd1;
        w_shift    = (w_lz < w_maxShift) ? w_lz : w_maxShift;

        if (w_raw[14]) begin
            w_norm = {w_raw[14:2], w_raw[1] | w_raw[0]};
            w_exp  = {1'b0, w_expBig} + 6'd1;
        end else begin
            w_norm = w_raw[13:0] << w_shift;
            w_exp  = {1'b0, w_expBig} - {1'b0, w_shift};
        end

        w_roundUp = w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]);
        w_manRnd  = {1'b0, w_norm[13:3]} + {11'd0, w_roundUp};
        w_expRnd  = w_manRnd[11] ? (w_exp + 6'd1) : w_exp;

        if (w_special || (w_expRnd >= 6'd31))
            o_sum = 16'hFFFF;
        else if (w_raw == 15'd0)
            o_sum = 16'h0000;
        else if (w_manRnd[11] | w_manRnd[10])
            o_sum = {w_big[15], w_expRnd[4:0], w_manRnd[9:0]};
        else
            o_sum = {w_big[15], 5'd0, w_manRnd[9:0]};
    end
endmodule

module fp16_accum #(
    parameter int LEN_W = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [15:0]      data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [15:0]      sum_o,
    output logic             busy_o,
`ifdef FP16_ACCUM_OVF_FLAG_EN
    output logic             ovf_o,
`endif
    output logic             done_o
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_ADD    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [15:0]      r_acc;
    logic [15:0]      r_opb;
    logic [LEN_W-1:0] r_cnt;
    logic             r_first;
    logic             r_done;
    logic             w_hs;
    logic [LEN_W-1:0] w_cntDec;
    logic [15:0]      w_addSum;

    fp16_add u_add (
        .i_a   (r_acc),
        .i_b   (r_opb),
        .o_sum (w_addSum)
    );

    assign w_hs     = valid_i & (r_state == S_ACCEPT);
    assign w_cntDec = r_cnt - {{(LEN_W-1){1'b0}}, 1'b1};
    assign sum_o    = r_acc;
    assign done_o   = r_done;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            r_state <= S_IDLE;
        else
            r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        ready_o     = 1'b0;
        busy_o      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (start_i && (len_i != '0))
                    w_stateNext = S_ACCEPT;
            end
            S_ACCEPT: begin
                ready_o = 1'b1;
                if (w_hs) begin
                    if (r_first)
                        w_stateNext = (w_cntDec != '0) ? S_ACCEPT : S_IDLE;
                    else
                        w_stateNext = S_ADD;
                end
            end
            S_ADD: begin
                w_stateNext = (r_cnt != '0) ? S_ACCEPT : S_IDLE;
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // The first element bypasses the adder; every later one costs an ADD cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_acc   <= 16'h0000;
            r_opb   <= 16'h0000;
            r_cnt   <= '0;
            r_first <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_acc <= 16'h0000;
                        if (len_i == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_cnt   <= len_i;
                            r_first <= 1'b1;
                        end
                    end
                end
                S_ACCEPT: begin
                    if (w_hs) begin
                        r_cnt <= w_cntDec;
                        if (r_first) begin
                            r_acc   <= data_i;
                            r_first <= 1'b0;
                            if (w_cntDec == '0)
                                r_done <= 1'b1;
                        end else begin
                            r_opb <= data_i;
                        end
                    end
                end
                S_ADD: begin
                    r_acc <= w_addSum;
                    if (r_cnt == '0)
                        r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef FP16_ACCUM_OVF_FLAG_EN
    logic r_ovf;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            r_ovf <= 1'b0;
        else if ((r_state == S_IDLE) && start_i)
            r_ovf <= 1'b0;
        else if (w_hs && r_first && (data_i == 16'hFFFF))
            r_ovf <= 1'b1;
        else if ((r_state == S_ADD) && (w_addSum == 16'hFFFF))
            r_ovf <= 1'b1;
    end

    assign ovf_o = r_ovf;
`endif
endmodule

// File: tb/tb_fp16_accum.sv
// Directed self-checking bench for fp16_accum with hand-computed FP16 sums.
// Checks ovf_o as well when FP16_ACCUM_OVF_FLAG_EN is defined.
`timescale 1ns/1ps

module tb_fp16_accum;
    localparam int LEN_W = 8;

    logic             clk_i   = 1'b0;
    logic             rstn_i  = 1'b0;
    logic             start_i = 1'b0;
    logic [LEN_W-1:0] len_i   = '0;
    logic [15:0]      data_i  = 16'h0000;
    logic             valid_i = 1'b0;
    logic             ready_o;
    logic [15:0]      sum_o;
    logic             busy_o;
    logic             done_o;
`ifdef FP16_ACCUM_OVF_FLAG_EN
    logic             ovf_o;
`endif

    int checks   = 0;
    int failures = 0;

    fp16_accum #(.LEN_W(LEN_W)) dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .start_i (start_i),
        .len_i   (len_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .sum_o   (sum_o),
        .busy_o  (busy_o),
`ifdef FP16_ACCUM_OVF_FLAG_EN
        .ovf_o   (ovf_o),
`endif
        .done_o  (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic [LEN_W-1:0] len,
                                 input logic vld, input logic [15:0] dat);
        start_i = st;
        len_i   = len;
        valid_i = vld;
        data_i  = dat;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic startRun(input logic [LEN_W-1:0] len);
        applyStimulus(1'b1, len, 1'b0, 16'h0000);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 16'h0000);
    endtask

    // Idles valid_i for gap cycles, then offers dat until the block takes it.
    task automatic sendElem(input logic [15:0] dat, input int gap);
        applyStimulus(1'b0, '0, 1'b0, 16'h0000);
        repeat (gap) tick();
        applyStimulus(1'b0, '0, 1'b1, dat);
        for (int k = 0; k < 8 && !ready_o; k++) tick();
        checkOutput("hs_ready", {15'd0, ready_o}, 16'd1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 16'h0000);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        #2;
        checkOutput("rst_sum",   sum_o,            16'h0000);
        checkOutput("rst_busy",  {15'd0, busy_o},  16'd0);
        checkOutput("rst_ready", {15'd0, ready_o}, 16'd0);
        checkOutput("rst_done",  {15'd0, done_o},  16'd0);
`ifdef FP16_ACCUM_OVF_FLAG_EN
        checkOutput("rst_ovf",   {15'd0, ovf_o},   16'd0);
`endif
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        tick();

        // 1.0 + 2.0 = 3.0
        startRun(8'd2);
        checkOutput("t1_busy",  {15'd0, busy_o},  16'd1);
        checkOutput("t1_ready", {15'd0, ready_o}, 16'd1);
        sendElem(16'h3C00, 0);
        checkOutput("t1_bypass", sum_o,           16'h3C00);
        sendElem(16'h4000, 0);
        checkOutput("t1_add_ready", {15'd0, ready_o}, 16'd0);
        checkOutput("t1_done_early", {15'd0, done_o}, 16'd0);
        tick();
        checkOutput("t1_done", {15'd0, done_o}, 16'd1);
        checkOutput("t1_sum",  sum_o,           16'h4200);
        checkOutput("t1_idle", {15'd0, busy_o}, 16'd0);
        tick();
        checkOutput("t1_done_pulse", {15'd0, done_o}, 16'd0);
        checkOutput("t1_hold", sum_o, 16'h4200);

        // Zero-length run clears the sum and finishes without accepting data.
        applyStimulus(1'b1, 8'd0, 1'b1, 16'h3C00);
        tick();
        checkOutput("len0_done",  {15'd0, done_o},  16'd1);
        checkOutput("len0_sum",   sum_o,            16'h0000);
        checkOutput("len0_busy",  {15'd0, busy_o},  16'd0);
        checkOutput("len0_ready", {15'd0, ready_o}, 16'd0);
        applyStimulus(1'b0, '0, 1'b0, 16'h0000);
        tick();
        checkOutput("len0_done_pulse", {15'd0, done_o},  16'd0);
        checkOutput("len0_ready2",     {15'd0, ready_o}, 16'd0);

        // Four ones with growing valid gaps.
        startRun(8'd4);
        sendElem(16'h3C00, 0);
        sendElem(16'h3C00, 1);
        checkOutput("t2_add_ready1", {15'd0, ready_o}, 16'd0);
        sendElem(16'h3C00, 2);
        checkOutput("t2_add_ready2", {15'd0, ready_o}, 16'd0);
        sendElem(16'h3C00, 3);
        checkOutput("t2_add_ready3", {15'd0, ready_o}, 16'd0);
        tick();
        checkOutput("t2_done", {15'd0, done_o}, 16'd1);
        checkOutput("t2_sum",  sum_o,           16'h4400);

        // Exact cancellation.
        startRun(8'd2);
        sendElem(16'h3C00, 0);
        sendElem(16'hBC00, 0);
        tick();
        checkOutput("t3_done", {15'd0, done_o}, 16'd1);
        checkOutput("t3_sum",  sum_o,           16'h0000);

        // Overflow of the largest finite value.
        startRun(8'd2);
        sendElem(16'h7BFF, 0);
        sendElem(16'h7BFF, 0);
        tick();
        checkOutput("t4_done", {15'd0, done_o}, 16'd1);
        checkOutput("t4_sum",  sum_o,           16'hFFFF);
`ifdef FP16_ACCUM_OVF_FLAG_EN
        checkOutput("t4_ovf", {15'd0, ovf_o}, 16'd1);
        tick();
        tick();
        checkOutput("t4_ovf_sticky", {15'd0, ovf_o}, 16'd1);
`endif

        // Single element goes straight into the accumulator.
        startRun(8'd1);
`ifdef FP16_ACCUM_OVF_FLAG_EN
        checkOutput("t5_ovf_clr", {15'd0, ovf_o}, 16'd0);
`endif
        sendElem(16'h5640, 0);
        checkOutput("t5_done", {15'd0, done_o}, 16'd1);
        checkOutput("t5_sum",  sum_o,           16'h5640);
        checkOutput("t5_idle", {15'd0, busy_o}, 16'd0);
        tick();
        checkOutput("t5_done_pulse", {15'd0, done_o}, 16'd0);

        // start_i while busy must not restart or reload the count.
        startRun(8'd3);
        sendElem(16'h3C00, 0);
        applyStimulus(1'b1, 8'd9, 1'b0, 16'h0000);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 16'h0000);
        checkOutput("t6_busy", {15'd0, busy_o}, 16'd1);
        checkOutput("t6_keep", sum_o,           16'h3C00);
        sendElem(16'h3C00, 0);
        applyStimulus(1'b1, 8'd9, 1'b0, 16'h0000);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 16'h0000);
        checkOutput("t6_done_early", {15'd0, done_o}, 16'd0);
        sendElem(16'h3C00, 0);
        tick();
        checkOutput("t6_done", {15'd0, done_o}, 16'd1);
        checkOutput("t6_sum",  sum_o,           16'h4200);

        // Asynchronous reset in the middle of an ADD cycle.
        startRun(8'd2);
        sendElem(16'h3C00, 0);
        sendElem(16'h3C00, 0);
        checkOutput("t7_in_add", sum_o, 16'h3C00);
        rstn_i = 1'b0;
        #1;
        checkOutput("t7_rst_sum",   sum_o,            16'h0000);
        checkOutput("t7_rst_busy",  {15'd0, busy_o},  16'd0);
        checkOutput("t7_rst_ready", {15'd0, ready_o}, 16'd0);
        checkOutput("t7_rst_done",  {15'd0, done_o},  16'd0);
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        applyStimulus(1'b0, '0, 1'b1, 16'h4000);
        tick();
        tick();
        checkOutput("t7_no_resume_busy", {15'd0, busy_o}, 16'd0);
        checkOutput("t7_no_resume_sum",  sum_o,           16'h0000);
        applyStimulus(1'b0, '0, 1'b0, 16'h0000);
        startRun(8'd1);
        sendElem(16'h4000, 0);
        checkOutput("t7_restart_done", {15'd0, done_o}, 16'd1);
        checkOutput("t7_restart_sum",  sum_o,           16'h4000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
